// File: rtl/instr_fetch.sv
// Instruction fetch unit: a ROM request FSM feeding a 2-entry {word, pc} FIFO.
// A jump_i redirect flushes the FIFO and drops any in-flight ROM result.
module instr_fetch #(
  parameter int unsigned           ADDR_WIDTH = 15,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  output logic                  rom_req_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic                  rom_ack_i,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  halt_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned CNT_WIDTH = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DISCARD} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  cnt_pop;
  entry_t                head_q, head_d;
  entry_t                tail_q, tail_d;
  entry_t                push_entry;
  logic                  pop;
  logic                  push;
  logic                  launch;

  // Next-state, fetch pointer and FIFO update; head entry always drives the outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = 1'b0;
    launch     = 1'b0;
    pop        = valid_q & instr_ready_i;
    cnt_pop    = count_q - CNT_WIDTH'(pop);
    push_entry = '{word: rom_data_i, pc: addr_q};

    unique case (state_q)
      ST_IDLE: begin
        if (!halt_i && !jump_i && cnt_pop <= CNT_WIDTH'(1)) begin
          state_d = ST_REQ;
          launch  = 1'b1;
        end
      end
      ST_REQ: begin
        if (jump_i) begin
          state_d = rom_ack_i ? ST_IDLE : ST_DISCARD;
        end else if (rom_ack_i) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_WIDTH'(1);
          // Back-to-back only if the FIFO keeps room for the next word.
          if (!halt_i && cnt_pop == '0) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (rom_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (jump_i) begin
      pc_d = jump_addr_i;
    end
    if (launch) begin
      addr_d = pc_d;
    end

    if (pop) begin
      head_d = tail_q;
    end
    if (push) begin
      if (cnt_pop == '0) begin
        head_d = push_entry;
      end else begin
        tail_d = push_entry;
      end
    end

    count_d = jump_i ? '0 : cnt_pop + CNT_WIDTH'(push);
    valid_d = (count_d != '0);
    req_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign rom_req_o     = req_q;
  assign rom_addr_o    = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = head_q.word;
  assign instr_pc_o    = head_q.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reset, streaming, backpressure, halt,
// redirects, wrap-around and mid-request reset, plus a scoreboarded random run.
module tb_instr_fetch;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [DW-1:0] word;
    logic [AW-1:0] pc;
  } exp_t;

  typedef struct {
    logic          rdy;
    logic          hlt;
    logic          req;
    logic          vld;
    logic [AW-1:0] pc;
    logic [AW-1:0] addr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rom_req, rom_ack;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          jump, halt, ready;
  logic [AW-1:0] jump_addr;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;

  logic          w_req, w_valid;
  logic [AW-1:0] w_addr, w_pc;
  logic [DW-1:0] w_data, w_instr;

  int            n_checks = 0;
  int            n_fail = 0;
  int            lat = 0;
  int            wait_cnt = 0;
  bit            sb_en = 1'b0;
  bit            pend = 1'b0;
  bit            done;
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] exp_fetch = '0;
  exp_t          sb_q[$];
  vec_t          tbl[10];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'(a) * 16'd7 + 16'h1234;
  endfunction

  // Behavioural ROM: acks after 'lat' wait cycles of an outstanding request.
  always @(posedge clk) begin
    if (!rom_req || rom_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end
  assign rom_ack  = rom_req && (wait_cnt >= lat);
  assign rom_data = rom_word(rom_addr);
  assign w_data   = rom_word(w_addr);

  instr_fetch dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_ack_i(rom_ack), .rom_data_i(rom_data),
    .jump_i(jump), .jump_addr_i(jump_addr), .halt_i(halt),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready)
  );

  instr_fetch #(.RESET_PC(15'h7FFF)) dut_w (
    .clk_i(clk), .reset_n_i(reset_n),
    .rom_req_o(w_req), .rom_addr_o(w_addr), .rom_ack_i(w_req), .rom_data_i(w_data),
    .jump_i(1'b0), .jump_addr_i('0), .halt_i(1'b0),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_pc),
    .instr_ready_i(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic rdy, input int l);
    @(negedge clk);
    reset_n = 1'b0;
    ready   = rdy;
    halt    = 1'b0;
    jump    = 1'b0;
    lat     = l;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Scoreboard: expected {word, pc} queued at each accepted ROM ack, checked at transfer.
  always @(negedge clk) begin
    if (sb_en && reset_n) begin
      if (instr_valid && ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got pc 0x%0h, expected no transfer", instr_pc);
        end else begin
          chk("sb_pc", 32'(instr_pc), 32'(sb_q[0].pc));
          chk("sb_word", 32'(instr), 32'(sb_q[0].word));
          void'(sb_q.pop_front());
        end
      end
      if (pend) chk("addr_stable", 32'(rom_addr), 32'(pend_addr));
      if (rom_req && rom_ack) begin
        chk("sb_addr", 32'(rom_addr), 32'(exp_fetch));
        sb_q.push_back('{word: rom_word(exp_fetch), pc: exp_fetch});
        exp_fetch <= exp_fetch + AW'(1);
      end
      pend      <= rom_req && !rom_ack;
      pend_addr <= rom_addr;
    end else begin
      pend      <= 1'b0;
      exp_fetch <= '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    // ready, halt driven after check; expected req, valid, pc, addr
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 15'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 15'd0, 15'd1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd0, 15'd1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 15'd0, 15'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 15'd1, 15'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 15'd2, 15'd3};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd3, 15'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd3, 15'd3};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 15'd3, 15'd4};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd3, 15'd4};

    reset_n = 1'b0; ready = 1'b0; halt = 1'b0; jump = 1'b0; jump_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'h7FFF);

    // Zero-wait streaming with ready=1
    ready = 1'b1; lat = 0; reset_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(rom_req), 32'd1);
    chk("first_addr", 32'(rom_addr), 32'd0);
    chk("first_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_valid", i), 32'(instr_valid), 32'd1);
      chk($sformatf("stream%0d_pc", i), 32'(instr_pc), 32'(i));
      chk($sformatf("stream%0d_word", i), 32'(instr), 32'(rom_word(AW'(i))));
      if (i == 0) chk("wrap_pc_first", 32'(w_pc), 32'h7FFF);
      if (i == 1) chk("wrap_pc_second", 32'(w_pc), 32'h0000);
    end

    // Backpressure fill, drain and halt across an outstanding request
    do_reset(1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), 32'(rom_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(tbl[i].addr));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
        chk($sformatf("tbl%0d_word", i), 32'(instr), 32'(rom_word(tbl[i].pc)));
      end
      ready = tbl[i].rdy;
      halt  = tbl[i].hlt;
    end
    halt = 1'b0;

    // Jump while waiting on a slow ROM: old word dropped, refetch at target
    do_reset(1'b1, 3);
    @(negedge clk);
    chk("j_wait1_req", 32'(rom_req), 32'd1);
    @(negedge clk);
    chk("j_wait2_addr", 32'(rom_addr), 32'd0);
    jump = 1'b1; jump_addr = 15'h0100;
    @(negedge clk);
    jump = 1'b0;
    chk("j_disc_req", 32'(rom_req), 32'd1);
    chk("j_disc_addr", 32'(rom_addr), 32'd0);
    chk("j_disc_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("j_ack_req", 32'(rom_req), 32'd1);
    @(negedge clk);
    chk("j_drop_req", 32'(rom_req), 32'd0);
    chk("j_drop_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("j_new_req", 32'(rom_req), 32'd1);
    chk("j_new_addr", 32'(rom_addr), 32'h0100);
    repeat (4) @(negedge clk);
    chk("j_out_valid", 32'(instr_valid), 32'd1);
    chk("j_out_pc", 32'(instr_pc), 32'h0100);
    chk("j_out_word", 32'(instr), 32'(rom_word(15'h0100)));

    // Jump coinciding with an ack and a transfer
    lat = 0;
    repeat (3) @(negedge clk);
    chk("j2_pre_valid", 32'(instr_valid), 32'd1);
    chk("j2_pre_ack", 32'(rom_ack), 32'd1);
    jump = 1'b1; jump_addr = 15'h02A0;
    @(negedge clk);
    jump = 1'b0;
    chk("j2_flush_valid", 32'(instr_valid), 32'd0);
    chk("j2_flush_req", 32'(rom_req), 32'd0);
    @(negedge clk);
    chk("j2_new_addr", 32'(rom_addr), 32'h02A0);
    @(negedge clk);
    chk("j2_out_pc", 32'(instr_pc), 32'h02A0);
    chk("j2_out_valid", 32'(instr_valid), 32'd1);

    // Reset pulsed during an outstanding request with a word buffered
    do_reset(1'b0, 2);
    repeat (4) @(negedge clk);
    chk("mr_pre_valid", 32'(instr_valid), 32'd1);
    chk("mr_pre_req", 32'(rom_req), 32'd1);
    chk("mr_pre_addr", 32'(rom_addr), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mr_req", 32'(rom_req), 32'd0);
    chk("mr_addr", 32'(rom_addr), 32'd0);
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_instr", 32'(instr), 32'd0);
    chk("mr_pc", 32'(instr_pc), 32'd0);
    repeat (2) @(negedge clk);
    lat = 0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mr_next_req", 32'(rom_req), 32'd1);
    chk("mr_next_addr", 32'(rom_addr), 32'd0);

    // Random ready/halt/latency run against the scoreboard
    sb_q.delete();
    do_reset(1'b1, 0);
    @(posedge clk); #1;
    sb_en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      ready = ($urandom_range(0, 3) != 0);
      halt  = ($urandom_range(0, 9) == 0);
      if (!rom_req) lat = int'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    halt = 1'b1; ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (!rom_req && !instr_valid) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    sb_en = 1'b0;
    halt = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
